// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - word-in / bit-out handshake bundle for the serializer
interface serializer_if #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
);
    logic [DATA_W-1:0] data_i;
    logic [MOD_W-1:0]  data_mod_i;
    logic              data_val_i;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              busy_o;

    modport master (
        output data_i, data_mod_i, data_val_i,
        input  ser_data_o, ser_data_val_o, busy_o
    );

    modport slave (
        input  data_i, data_mod_i, data_val_i,
        output ser_data_o, ser_data_val_o, busy_o
    );
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter, MSB first, per-bit valid strobe
// Optional one-entry pending buffer for gapless back-to-back words: SERIALIZER_SKID_EN
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic        clk_i,
    input  logic        arst_i,
    serializer_if.slave bus_if
);
    localparam int CNT_W = MOD_W + 1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ser_data_q;
    logic              ser_val_q;
    logic              busy_q;

    logic              legal_w;
    logic [CNT_W-1:0]  len_w;
    logic              req_w;
    logic              last_w;
    logic              load_d;
    logic [DATA_W-1:0] load_data_d;
    logic [CNT_W-1:0]  load_len_d;

`ifdef SERIALIZER_SKID_EN
    logic [DATA_W-1:0] buf_data_q;
    logic [CNT_W-1:0]  buf_len_q;
    logic              buf_full_q;
`endif

    // Lengths 1 and 2 are dropped on acceptance; 0 encodes a full word.
    assign legal_w = (bus_if.data_mod_i == '0) || (bus_if.data_mod_i >= MOD_W'(3));
    assign len_w   = (bus_if.data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, bus_if.data_mod_i};
    assign req_w   = bus_if.data_val_i && !busy_q && legal_w;
    assign last_w  = (cnt_q == CNT_W'(1));

    always_comb begin
        load_d      = 1'b0;
        load_data_d = bus_if.data_i;
        load_len_d  = len_w;
        if (state_q == IDLE) begin
            load_d = req_w;
        end else if (last_w) begin
`ifdef SERIALIZER_SKID_EN
            if (buf_full_q) begin
                load_d      = 1'b1;
                load_data_d = buf_data_q;
                load_len_d  = buf_len_q;
            end else begin
                load_d = req_w;
            end
`else
            load_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            ser_data_q <= 1'b0;
            ser_val_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SERIALIZER_SKID_EN
            buf_data_q <= '0;
            buf_len_q  <= '0;
            buf_full_q <= 1'b0;
`endif
        end else begin
            if (load_d) begin
                // First bit goes straight to the output register; the rest queue up in shreg.
                state_q    <= SHIFT;
                shreg_q    <= {load_data_d[DATA_W-2:0], 1'b0};
                cnt_q      <= load_len_d;
                ser_data_q <= load_data_d[DATA_W-1];
                ser_val_q  <= 1'b1;
            end else if (state_q == SHIFT && last_w) begin
                state_q    <= IDLE;
                shreg_q    <= '0;
                cnt_q      <= '0;
                ser_data_q <= 1'b0;
                ser_val_q  <= 1'b0;
            end else if (state_q == SHIFT) begin
                shreg_q    <= {shreg_q[DATA_W-2:0], 1'b0};
                cnt_q      <= cnt_q - CNT_W'(1);
                ser_data_q <= shreg_q[DATA_W-1];
                ser_val_q  <= 1'b1;
            end

`ifdef SERIALIZER_SKID_EN
            if (state_q == SHIFT && last_w) begin
                buf_full_q <= 1'b0;
            end else if (state_q == SHIFT && req_w) begin
                buf_data_q <= bus_if.data_i;
                buf_len_q  <= len_w;
                buf_full_q <= 1'b1;
            end
            busy_q <= (state_q == SHIFT) && !last_w && (buf_full_q || req_w);
`else
            busy_q <= load_d || ((state_q == SHIFT) && !last_w);
`endif
        end
    end

    assign bus_if.ser_data_o     = ser_data_q;
    assign bus_if.ser_data_val_o = ser_val_q;
    assign bus_if.busy_o         = busy_q;
endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - randomized bench for serializer against a bit-queue reference model
module tb_serializer;
    localparam int DATA_W = 16;
    localparam int MOD_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus();

    serializer #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
        .clk_i  (clk),
        .arst_i (rst),
        .bus_if (bus)
    );

    int checks = 0;
    int errors = 0;

    // Bits still to appear on the line (front = this cycle) and the lengths of the words they belong to.
    bit bitq[$];
    int lens[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_busy();
`ifdef SERIALIZER_SKID_EN
        return lens.size() > 1;
`else
        return bitq.size() > 0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        logic ev, ed;
        ev = (bitq.size() > 0);
        ed = ev ? bitq[0] : 1'b0;
        check({tag, ".val"},  {31'd0, bus.ser_data_val_o}, {31'd0, ev});
        check({tag, ".data"}, {31'd0, bus.ser_data_o},     {31'd0, ed});
        check({tag, ".busy"}, {31'd0, bus.busy_o},         {31'd0, model_busy()});
    endtask

    task automatic model_edge(input logic v, input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] m);
        bit busy;
        int len;
        busy = model_busy();
        if (bitq.size() > 0) begin
            void'(bitq.pop_front());
            lens[0] = lens[0] - 1;
            if (lens[0] == 0) void'(lens.pop_front());
        end
        if (v && !busy && (m == 0 || m >= 3)) begin
            len = (m == 0) ? DATA_W : int'(m);
            for (int i = 0; i < len; i++) bitq.push_back(d[DATA_W-1-i]);
            lens.push_back(len);
        end
    endtask

    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] m,
                         input string tag);
        @(negedge clk);
        check_outputs(tag);
        bus.data_val_i = v;
        bus.data_i     = d;
        bus.data_mod_i = m;
        @(posedge clk);
        model_edge(v, d, m);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, DATA_W'($urandom), MOD_W'($urandom), tag);
    endtask

    initial begin
        logic [MOD_W-1:0] m;
        int r;

        bus.data_val_i = 1'b0;
        bus.data_i     = '0;
        bus.data_mod_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        cycle(1'b1, 16'hA5C3, 4'd0, "a5c3");
        idle(18, "a5c3");

        cycle(1'b1, 16'hF000, 4'd5, "f000");
        idle(7, "f000");

        cycle(1'b1, 16'hFFFF, 4'd1, "mod1");
        cycle(1'b1, 16'hFFFF, 4'd2, "mod2");
        idle(2, "illegal");
        cycle(1'b1, 16'hC35A, 4'd9, "after_illegal");
        idle(11, "after_illegal");

        for (int i = 0; i < 40; i++) cycle(1'b1, DATA_W'($urandom), 4'd0, "hold");
        idle(36, "hold");

        cycle(1'b1, 16'hA5C3, 4'd0, "rst_mid");
        idle(7, "rst_mid");
        #2 rst = 1'b1;
        #1;
        check("async_rst.val",  {31'd0, bus.ser_data_val_o}, 32'd0);
        check("async_rst.data", {31'd0, bus.ser_data_o},     32'd0);
        check("async_rst.busy", {31'd0, bus.busy_o},         32'd0);
        bitq.delete();
        lens.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 16'h8001, 4'd0, "post_rst");
        idle(18, "post_rst");

        cycle(1'b1, 16'hFFFF, 4'd0, "skid");
        idle(3, "skid");
        cycle(1'b1, 16'h0000, 4'd4, "skid");
        idle(24, "skid");

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       m = 4'd0;
            else if (r == 2) m = 4'd1;
            else if (r == 3) m = 4'd2;
            else             m = MOD_W'($urandom_range(3, 15));
            cycle(($urandom_range(0, 3) != 0), DATA_W'($urandom), m, "rand");
        end
        idle(2 * DATA_W + 4, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
